// File: rtl/regmem_reader_pkg.sv
// Shared types and width helpers for the register-memory stream reader.
package regmem_reader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_t;

  localparam int unsigned BUF_DEPTH = 2;

  function automatic int unsigned addr_width(input int unsigned height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

  function automatic int unsigned len_width(input int unsigned height);
    return $clog2(height) + 1;
  endfunction

endpackage

// File: rtl/regmem_skid_fifo.sv
// Two-entry FIFO for {last, data} words; push on full is accepted only with a same-cycle pop.
module regmem_skid_fifo
  import regmem_reader_pkg::*;
#(
  parameter int unsigned DW = 17
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic [1:0]    count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [BUF_DEPTH];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'(BUF_DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // One-bit pointers: the depth is fixed at two entries.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/regmem_stream_reader.sv
// Command-driven sequential reader for a 1-cycle-latency register memory, emitting a valid/ready
// stream with a last flag. Define REGMEM_READER_WRAP_EN to let addresses wrap at HEIGHT.
module regmem_stream_reader
  import regmem_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned HEIGHT = 16,
  parameter int unsigned LW = len_width(HEIGHT),
  localparam int unsigned AW = addr_width(HEIGHT)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmdValid_i,
  output logic             cmdReady_o,
  input  logic [AW-1:0]    cmdAddr_i,
  input  logic [LW-1:0]    cmdLen_i,
  output logic             memReadEnable_o,
  output logic [AW-1:0]    memReadAddr_o,
  input  logic [WIDTH-1:0] memReadData_i,
  output logic             dataValid_o,
  input  logic             dataReady_i,
  output logic [WIDTH-1:0] data_o,
  output logic             dataLast_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o
);

  localparam int unsigned EW = LW + 1;

  state_t         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d, rd_addr_q, addr_inc;
  logic [LW-1:0]  remaining_q, remaining_d;
  logic           inflight_q, inflight_last_q;
  logic           done_q, done_d, error_q, error_d;
  logic           issue, pop, last_pop, reject;
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]     fifo_count, occupancy;
  logic [WIDTH:0] fifo_head;
  logic [EW-1:0]  addr_ext, len_ext;

  assign addr_ext = EW'(cmdAddr_i);
  assign len_ext  = EW'(cmdLen_i);

`ifdef REGMEM_READER_WRAP_EN
  assign addr_inc = (addr_q == AW'(HEIGHT - 1)) ? '0 : addr_q + AW'(1);
  assign reject   = (addr_ext >= EW'(HEIGHT)) || (len_ext > EW'(HEIGHT));
`else
  assign addr_inc = addr_q + AW'(1);
  assign reject   = (addr_ext >= EW'(HEIGHT)) || (len_ext > EW'(HEIGHT)) ||
                    (addr_ext + len_ext > EW'(HEIGHT));
`endif

  // A word in flight is presented straight from the memory when the buffer is empty,
  // so the first word appears two cycles after accept.
  assign dataValid_o = inflight_q || !fifo_empty;
  assign pop         = dataValid_o && dataReady_i;
  assign fifo_pop    = pop && !fifo_empty;
  assign fifo_push   = inflight_q && !(pop && fifo_empty);
  assign occupancy   = fifo_count + {1'b0, inflight_q};
  assign issue       = (state_q == StRun) && (remaining_q != '0) &&
                       ((occupancy - {1'b0, pop}) < 2'(BUF_DEPTH));

  always_comb begin
    data_o     = '0;
    dataLast_o = 1'b0;
    if (!fifo_empty) begin
      {dataLast_o, data_o} = fifo_head;
    end else if (inflight_q) begin
      data_o     = memReadData_i;
      dataLast_o = inflight_last_q;
    end
  end

  assign last_pop        = pop && dataLast_o;
  assign memReadEnable_o = issue;
  assign memReadAddr_o   = issue ? addr_q : rd_addr_q;
  assign cmdReady_o      = (state_q == StIdle) && !done_q;
  assign busy_o          = (state_q != StIdle);
  assign done_o          = done_q || ((state_q == StDrain) && last_pop);
  assign error_o         = error_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmdValid_i && cmdReady_o) begin
          if (reject) begin
            done_d  = 1'b1;
            error_d = 1'b1;
          end else if (cmdLen_i == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = cmdAddr_i;
            remaining_d = cmdLen_i;
            state_d     = StRun;
          end
        end
      end
      StRun: begin
        if (issue) begin
          addr_d      = addr_inc;
          remaining_d = remaining_q - LW'(1);
          if (remaining_q == LW'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (last_pop) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      rd_addr_q       <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (remaining_q == LW'(1));
      done_q          <= done_d;
      error_q         <= error_d;
      if (issue) rd_addr_q <= addr_q;
    end
  end

  regmem_skid_fifo #(
    .DW(WIDTH + 1)
  ) u_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .push_i     (fifo_push),
    .push_data_i({inflight_last_q, memReadData_i}),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // In-flight plus buffered words never exceed the buffer depth.
  assert property (@(posedge clk_i) disable iff (reset_i) !(fifo_full && inflight_q));

endmodule
